msrv32_ahb_mem_responder: RTL and testbench

- AHB-Lite-style memory responder for the msrv32 core. It is the slave end of the core's data-memory interface (htrans/addr/write/mask/wdata in; rdata/ready/resp out).
- It also provides a read-only instruction fetch port on the same unified word array.
- Programmable wait states, error response for out-of-range addresses, and byte-masked writes.
- Used as the memory model/slave in core-level simulation and FPGA bring-up.

---
 rtl/msrv32_ahb_mem_responder.sv | 137 +++++++++++++
 tb/tb_msrv32_ahb_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_ahb_mem_responder.sv
`default_nettype none
// msrv32_ahb_mem_responder: AHB-Lite style memory slave with wait states, error response and an instruction port.
// Revision 1.0 - initial release
module msrv32_ahb_mem_responder #(
  parameter int          MEM_DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          WAIT_STATES    = 1,
  parameter string       INIT_FILE      = ""
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [1:0]  ahb_htrans_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [31:0] ms_riscv32_mp_imaddr_in,
  output logic [31:0] ms_riscv32_mp_instr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out
);

  localparam int          DEPTH   = 1 << MEM_DEPTH_LOG2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    DONE = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [31:0]               mem [DEPTH];
  logic [31:0]               dm_off, im_off, merged;
  logic [MEM_DEPTH_LOG2-1:0] dm_idx, im_idx, idx_q, rd_idx;
  logic                      dm_hit, im_hit;
  logic                      write_q;
  logic [3:0]                mask_q;
  logic [3:0]                cnt;
  logic                      accept, commit, load_rd;

  // Offset compare below the base wraps to a huge value, so one unsigned test covers both bounds.
  assign dm_off = ms_riscv32_mp_dmaddr_in - BASE_ADDR;
  assign dm_idx = dm_off[MEM_DEPTH_LOG2+1:2];
  assign dm_hit = (dm_off >> (MEM_DEPTH_LOG2 + 2)) == 32'd0;
  assign im_off = ms_riscv32_mp_imaddr_in - BASE_ADDR;
  assign im_idx = im_off[MEM_DEPTH_LOG2+1:2];
  assign im_hit = (im_off >> (MEM_DEPTH_LOG2 + 2)) == 32'd0;

  assign accept = ahb_htrans_in[1] && ahb_ready_out;
  assign commit = (state == DONE) && write_q && !ms_riscv32_mp_rst_in;
  assign rd_idx = (state == WAIT) ? idx_q : dm_idx;

  always_comb begin
    state_nxt     = state;
    load_rd       = 1'b0;
    ahb_ready_out = 1'b1;
    ahb_resp_out  = 1'b0;
    case (state)
      IDLE, DONE, ERR2: begin
        ahb_resp_out = (state == ERR2);
        state_nxt    = IDLE;
        if (ahb_htrans_in[1]) begin
          if (!dm_hit) begin
            state_nxt = ERR1;
          end else if (WAIT_STATES == 0) begin
            state_nxt = DONE;
            load_rd   = !ms_riscv32_mp_dmwr_req_in;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        ahb_ready_out = 1'b0;
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          load_rd   = !write_q;
        end
      end
      ERR1: begin
        ahb_ready_out = 1'b0;
        ahb_resp_out  = 1'b1;
        state_nxt     = ERR2;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A read loaded on the edge a same-word write commits sees the post-write word.
  always_comb begin
    merged = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) merged[8*i +: 8] = ms_riscv32_mp_dmdata_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state                    <= IDLE;
      cnt                      <= 4'd0;
      idx_q                    <= '0;
      write_q                  <= 1'b0;
      mask_q                   <= 4'd0;
      ms_riscv32_mp_dmdata_out <= 32'd0;
      ms_riscv32_mp_instr_out  <= NOP;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q   <= dm_idx;
        write_q <= ms_riscv32_mp_dmwr_req_in;
        mask_q  <= ms_riscv32_mp_dmwr_mask_in;
      end
      if (accept && (state_nxt == WAIT)) cnt <= WS_LOAD;
      else if ((state == WAIT) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
      if (load_rd) ms_riscv32_mp_dmdata_out <= merged;
      ms_riscv32_mp_instr_out <= im_hit ? mem[im_idx] : NOP;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[idx_q][8*i +: 8] <= ms_riscv32_mp_dmdata_in[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_ahb_mem_responder.sv
`default_nettype none
// tb_msrv32_ahb_mem_responder: scoreboard bench over two responders (1 and 0 wait states).
// Revision 1.0 - initial release
module tb_msrv32_ahb_mem_responder;

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    bit          resp;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  htrans [2];
  logic [31:0] addr   [2];
  logic        wr     [2];
  logic [3:0]  mask   [2];
  logic [31:0] wdata  [2];
  logic [31:0] imaddr [2];
  logic [31:0] instr  [2];
  logic [31:0] rdata  [2];
  logic        ready  [2];
  logic        resp   [2];

  exp_t q0[$];
  exp_t q1[$];
  bit   pending [2];
  int   waits   [2];
  bit   wresp   [2];
  int   asserts = 0;
  int   fails   = 0;

  always #5 clk = ~clk;

  msrv32_ahb_mem_responder #(.MEM_DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_STATES(1), .INIT_FILE("")) u_ws1 (
    .ms_riscv32_mp_clk_in       (clk),
    .ms_riscv32_mp_rst_in       (rst),
    .ahb_htrans_in              (htrans[0]),
    .ms_riscv32_mp_dmaddr_in    (addr[0]),
    .ms_riscv32_mp_dmwr_req_in  (wr[0]),
    .ms_riscv32_mp_dmwr_mask_in (mask[0]),
    .ms_riscv32_mp_dmdata_in    (wdata[0]),
    .ms_riscv32_mp_imaddr_in    (imaddr[0]),
    .ms_riscv32_mp_instr_out    (instr[0]),
    .ms_riscv32_mp_dmdata_out   (rdata[0]),
    .ahb_ready_out              (ready[0]),
    .ahb_resp_out               (resp[0])
  );

  msrv32_ahb_mem_responder #(.MEM_DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
    .ms_riscv32_mp_clk_in       (clk),
    .ms_riscv32_mp_rst_in       (rst),
    .ahb_htrans_in              (htrans[1]),
    .ms_riscv32_mp_dmaddr_in    (addr[1]),
    .ms_riscv32_mp_dmwr_req_in  (wr[1]),
    .ms_riscv32_mp_dmwr_mask_in (mask[1]),
    .ms_riscv32_mp_dmdata_in    (wdata[1]),
    .ms_riscv32_mp_imaddr_in    (imaddr[1]),
    .ms_riscv32_mp_instr_out    (instr[1]),
    .ms_riscv32_mp_dmdata_out   (rdata[1]),
    .ahb_ready_out              (ready[1]),
    .ahb_resp_out               (resp[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input exp_t e);
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Presents an address phase from posedge+1 and returns at posedge+1 after the accepting edge,
  // with the write data for its data phase already driven.
  task automatic issue(input int g, input bit w, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d);
    bit ok;
    ok        = 1'b0;
    htrans[g] = 2'b10;
    addr[g]   = a;
    wr[g]     = w;
    mask[g]   = m;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("accept_timeout_dut%0d", g), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    htrans[g] = 2'b00;
    wdata[g]  = d;
  endtask

  task automatic wr_xfer(input int g, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    exp_t e;
    e.chk_data = 1'b0;
    e.data     = 32'd0;
    e.resp     = 1'b0;
    e.waits    = (g == 0) ? 1 : 0;
    push(g, e);
    issue(g, 1'b1, a, m, d);
  endtask

  task automatic rd_xfer(input int g, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.chk_data = 1'b1;
    e.data     = d;
    e.resp     = 1'b0;
    e.waits    = (g == 0) ? 1 : 0;
    push(g, e);
    issue(g, 1'b0, a, 4'h0, 32'd0);
  endtask

  task automatic err_xfer(input int g, input logic [31:0] a, input logic [31:0] held);
    exp_t e;
    e.chk_data = 1'b1;
    e.data     = held;
    e.resp     = 1'b1;
    e.waits    = 1;
    push(g, e);
    issue(g, 1'b0, a, 4'h0, 32'd0);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !pending[0] && !pending[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: tracks each data phase and scores it at its completion cycle.
  initial begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      pending[g] = 1'b0;
      waits[g]   = 0;
      wresp[g]   = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          pending[g] = 1'b0;
          waits[g]   = 0;
          wresp[g]   = 1'b0;
        end else begin
          if (pending[g]) begin
            if (!ready[g]) begin
              waits[g]++;
              wresp[g] = wresp[g] | resp[g];
            end else begin
              pending[g] = 1'b0;
              if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                check($sformatf("unexpected_completion_dut%0d", g), 32'd1, 32'd0);
              end else begin
                if (g == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("resp_dut%0d", g), {31'd0, resp[g]}, {31'd0, e.resp});
                check($sformatf("wait_cycles_dut%0d", g), waits[g], e.waits);
                check($sformatf("wait_resp_dut%0d", g), {31'd0, wresp[g]},
                      {31'd0, e.resp && (e.waits > 0)});
                if (e.chk_data) check($sformatf("rdata_dut%0d", g), rdata[g], e.data);
              end
            end
          end
          if (htrans[g][1] && ready[g]) begin
            pending[g] = 1'b1;
            waits[g]   = 0;
            wresp[g]   = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      htrans[g] = 2'b00;
      addr[g]   = 32'd0;
      wr[g]     = 1'b0;
      mask[g]   = 4'h0;
      wdata[g]  = 32'd0;
      imaddr[g] = 32'h0000_2000;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_ready_dut%0d", g), {31'd0, ready[g]}, 32'd1);
      check($sformatf("rst_resp_dut%0d", g), {31'd0, resp[g]}, 32'd0);
      check($sformatf("rst_rdata_dut%0d", g), rdata[g], 32'd0);
      check($sformatf("rst_instr_dut%0d", g), instr[g], 32'h0000_0013);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // One wait state: full write then read back; unaligned low bits ignored; zero mask is a no-op.
    wr_xfer(0, 32'h10, 4'hF, 32'hDEAD_BEEF);
    rd_xfer(0, 32'h10, 32'hDEAD_BEEF);
    wr_xfer(0, 32'h10, 4'h0, 32'h0000_0000);
    rd_xfer(0, 32'h13, 32'hDEAD_BEEF);
    drain();

    // Byte-lane merge.
    wr_xfer(0, 32'h20, 4'hF, 32'h1122_3344);
    wr_xfer(0, 32'h20, 4'b0101, 32'hAABB_CCDD);
    rd_xfer(0, 32'h20, 32'h11BB_33DD);
    drain();

    // First word past the array: ERR1 then ERR2, read data held, then back to idle.
    err_xfer(0, 32'h0000_1000, 32'h11BB_33DD);
    drain();
    @(negedge clk);
    check("idle_ready_after_err", {31'd0, ready[0]}, 32'd1);
    check("idle_resp_after_err", {31'd0, resp[0]}, 32'd0);
    @(posedge clk);
    #1;
    rd_xfer(0, 32'h20, 32'h11BB_33DD);
    drain();

    // Zero wait states: back-to-back write then read of the same word, plus the last word.
    wr_xfer(1, 32'h40, 4'hF, 32'h1234_5678);
    rd_xfer(1, 32'h40, 32'h1234_5678);
    drain();
    wr_xfer(1, 32'hFFC, 4'hF, 32'hCAFE_F00D);
    rd_xfer(1, 32'hFFC, 32'hCAFE_F00D);
    drain();

    // Instruction port on word 0 and out of range.
    wr_xfer(0, 32'h0, 4'hF, 32'h0010_0093);
    drain();
    imaddr[0] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check("instr_word0", instr[0], 32'h0010_0093);
    @(posedge clk);
    #1;
    imaddr[0] = 32'h10;
    imaddr[1] = 32'h0000_1000;
    @(posedge clk);
    @(negedge clk);
    check("instr_word4", instr[0], 32'hDEAD_BEEF);
    check("instr_out_of_range", instr[1], 32'h0000_0013);
    @(posedge clk);
    #1;

    // Reset during the wait state of a write leaves the old word intact.
    wr_xfer(0, 32'h50, 4'hF, 32'h0000_0000);
    drain();
    issue(0, 1'b1, 32'h50, 4'hF, 32'hFEED_FACE);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_rdata_cleared", rdata[0], 32'd0);
    check("midreset_ready", {31'd0, ready[0]}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_xfer(0, 32'h50, 32'h0000_0000);
    rd_xfer(0, 32'h10, 32'hDEAD_BEEF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
